cache_hierarchy: RTL
====================

CACHE_HIERARCHY -- requirements
Module: cache_hierarchy

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, word width; ADDR_WIDTH, 8, word-address width; L1_LOG_LINES, 2, log2 L1 lines; L2_LOG_LINES, 3, log2 L2 lines (one word per line, direct-mapped, L1_LOG_LINES <= L2_LOG_LINES < ADDR_WIDTH).
REQ-002 SHALL have ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when both high at a rising edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- flush  in  1  invalidate all L1/L2 lines.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- resp_level  out  2  source: 0 = L1, 1 = L2, 2 = memory.
- mem_req_valid  out  1  memory request, held until acknowledged.
- mem_req_write  out  1  memory write.
- mem_req_addr  out  ADDR_WIDTH  memory address.
- mem_req_wdata  out  DATA_WIDTH  memory write data.
- mem_resp_valid  in  1  memory acknowledge/data strobe.
- mem_resp_rdata  in  DATA_WIDTH  memory read data.
- l1_hit_cnt, l1_miss_cnt, l2_hit_cnt, l2_miss_cnt  out  32 each  statistics.

Function
REQ-003 SHALL use index = addr[LOG_LINES-1:0] and tag = the remaining upper bits per level, with one valid bit per line.
REQ-004 SHALL implement the FSM IDLE -> L1 -> L2 -> MEM -> RESP -> IDLE; states are skipped as given below.
REQ-005 SHALL drive req_ready = (state == IDLE) && !flush; the request is registered on acceptance.
REQ-006 SHALL exit L1 to RESP on a read hit (resp_level 0); otherwise to L2.
REQ-007 SHALL, on an L2 read hit, fill the L1 line and go to RESP (resp_level 1); on an L2 read miss, go to MEM.
REQ-008 SHALL, in MEM, hold mem_req_valid and registered addr/wdata/write until the cycle mem_resp_valid = 1; mem_resp_valid outside MEM is ignored.
REQ-009 SHALL, on a read, latch mem_resp_rdata and fill both L1 and L2 with it, then go to RESP (resp_level 2).
REQ-010 SHALL handle writes as write-through, no-write-allocate: update data in each level that hits (L1 state, L2 state), always traverse MEM with mem_req_write = 1, and never allocate on a miss.
REQ-011 SHALL, for a write, report resp_level 2 and resp_rdata 0.
REQ-012 SHALL set latency from acceptance edge T: L1 hit resp_valid in cycle T+2; L2 hit T+3; memory, the cycle after mem_resp_valid.
REQ-013 SHALL assert resp_valid for exactly one cycle, with no backpressure.
REQ-014 SHALL clear all valid bits at the edge where flush = 1 in IDLE; flush outside IDLE is ignored.
REQ-015 SHALL give flush priority over a simultaneous req_valid, which is not accepted that cycle.
REQ-016 SHALL count one lookup per level visited (hit or miss, reads and writes); counters saturate at 32'hFFFFFFFF and are not cleared by flush.

Reset
REQ-017 SHALL, while rst = 0, immediately force: state IDLE, all valid bits 0, req_ready 0, resp_valid 0, resp_rdata 0, resp_level 0, mem_req_valid 0, mem_req_write 0, mem_req_addr 0, mem_req_wdata 0, all counters 0.
REQ-018 SHALL abandon an in-flight request on reset mid-operation, with no response issued.
REQ-019 SHALL drive req_ready 1 on the first clock edge after rst rises.

Configuration
REQ-020 SHALL implement the counters only when CACHE_STATS_EN is defined; without the macro the counter ports SHALL be present and tied to 0, and function is otherwise identical.

Verification (defaults; memory answers 3 cycles after mem_req_valid)
REQ-021 Read 0x14 after reset, memory returns 0xDEADBEEF -> mem_req_valid with addr 0x14, resp 0xDEADBEEF, level 2; re-read 0x14 -> resp at T+2, level 0, no mem_req_valid.
REQ-022 Read 0x14, read 0x18 (L1 conflict), re-read 0x14 -> resp at T+3, level 1, data 0xDEADBEEF, no mem_req_valid.
REQ-023 With 0x14 cached, write 0x12345678 -> mem write of 0x12345678 to 0x14, level 2; re-read -> 0x12345678, level 0.
REQ-024 Write 0x40 (uncached), then read 0x40 -> read goes to memory, level 2 (no allocate); flush with req_valid high -> req_ready 0 that cycle, next read 0x14 level 2.
REQ-025 Assert rst while in MEM -> mem_req_valid 0 immediately, no resp_valid; after release, read 0x14 -> level 2.
REQ-026 With CACHE_STATS_EN, after REQ-021 -> l1_hit 1, l1_miss 1, l2_hit 0, l2_miss 1; without the macro -> all 0.

Source files
------------

// File: rtl/cache_hierarchy.sv
// Two-level direct-mapped write-through cache (L1 + L2, one word per line) in front of a handshaked memory.
// Statistics counters are built only when CACHE_STATS_EN is defined; otherwise the counter ports read 0.
module cache_hierarchy #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int L1_LOG_LINES = 2,
  parameter int L2_LOG_LINES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_level,
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic [31:0]           l1_hit_cnt,
  output logic [31:0]           l1_miss_cnt,
  output logic [31:0]           l2_hit_cnt,
  output logic [31:0]           l2_miss_cnt,
  output logic [2:0]            dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; resp_valid is a single-cycle pulse that cannot be stalled, and
  // mem_req_valid stays high until the edge that samples mem_resp_valid = 1.

  localparam int L1_LINES = 1 << L1_LOG_LINES;
  localparam int L2_LINES = 1 << L2_LOG_LINES;
  localparam int L1_TAG_W = ADDR_WIDTH - L1_LOG_LINES;
  localparam int L2_TAG_W = ADDR_WIDTH - L2_LOG_LINES;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_MEM  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state;
  logic   ready_en;

  logic                  op_write;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;

  logic [L1_LINES-1:0]   l1_valid;
  logic [L1_TAG_W-1:0]   l1_tag  [L1_LINES];
  logic [DATA_WIDTH-1:0] l1_data [L1_LINES];
  logic [L2_LINES-1:0]   l2_valid;
  logic [L2_TAG_W-1:0]   l2_tag  [L2_LINES];
  logic [DATA_WIDTH-1:0] l2_data [L2_LINES];

  logic [L1_LOG_LINES-1:0] l1_idx;
  logic [L1_TAG_W-1:0]     l1_tg;
  logic [L2_LOG_LINES-1:0] l2_idx;
  logic [L2_TAG_W-1:0]     l2_tg;
  logic                    l1_hit;
  logic                    l2_hit;

  assign l1_idx = op_addr[L1_LOG_LINES-1:0];
  assign l1_tg  = op_addr[ADDR_WIDTH-1:L1_LOG_LINES];
  assign l2_idx = op_addr[L2_LOG_LINES-1:0];
  assign l2_tg  = op_addr[ADDR_WIDTH-1:L2_LOG_LINES];
  assign l1_hit = l1_valid[l1_idx] && (l1_tag[l1_idx] == l1_tg);
  assign l2_hit = l2_valid[l2_idx] && (l2_tag[l2_idx] == l2_tg);

  // ready_en keeps req_ready low during reset and for the cycle it is released.
  assign req_ready = ready_en && (state == S_IDLE) && !flush;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      ready_en      <= 1'b0;
      op_write      <= 1'b0;
      op_addr       <= '0;
      op_wdata      <= '0;
      l1_valid      <= '0;
      l2_valid      <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_level    <= 2'd0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (flush) begin
            l1_valid <= '0;
            l2_valid <= '0;
          end else if (req_valid && req_ready) begin
            op_write <= req_write;
            op_addr  <= req_addr;
            op_wdata <= req_wdata;
            state    <= S_L1;
          end
        end
        S_L1: begin
          if (!op_write && l1_hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= l1_data[l1_idx];
            resp_level <= 2'd0;
            state      <= S_RESP;
          end else begin
            state <= S_L2;
          end
        end
        S_L2: begin
          if (!op_write && l2_hit) begin
            l1_valid[l1_idx] <= 1'b1;
            resp_valid       <= 1'b1;
            resp_rdata       <= l2_data[l2_idx];
            resp_level       <= 2'd1;
            state            <= S_RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_write <= op_write;
            mem_req_addr  <= op_addr;
            mem_req_wdata <= op_wdata;
            state         <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_resp_valid) begin
            mem_req_valid <= 1'b0;
            resp_valid    <= 1'b1;
            resp_level    <= 2'd2;
            if (op_write) begin
              resp_rdata <= '0;
            end else begin
              resp_rdata       <= mem_resp_rdata;
              l1_valid[l1_idx] <= 1'b1;
              l2_valid[l2_idx] <= 1'b1;
            end
            state <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; only the valid bits decide whether a line is live.
  always_ff @(posedge clk) begin
    if (state == S_L1 && op_write && l1_hit) begin
      l1_data[l1_idx] <= op_wdata;
    end
    if (state == S_L2) begin
      if (op_write && l2_hit) begin
        l2_data[l2_idx] <= op_wdata;
      end else if (!op_write && l2_hit) begin
        l1_tag[l1_idx]  <= l1_tg;
        l1_data[l1_idx] <= l2_data[l2_idx];
      end
    end
    if (state == S_MEM && mem_resp_valid && !op_write) begin
      l1_tag[l1_idx]  <= l1_tg;
      l1_data[l1_idx] <= mem_resp_rdata;
      l2_tag[l2_idx]  <= l2_tg;
      l2_data[l2_idx] <= mem_resp_rdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic l1_lookup;
  logic l2_lookup;
  assign l1_lookup = (state == S_L1);
  assign l2_lookup = (state == S_L2);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l1_hit_cnt  <= '0;
      l1_miss_cnt <= '0;
      l2_hit_cnt  <= '0;
      l2_miss_cnt <= '0;
    end else begin
      if (l1_lookup && l1_hit)  l1_hit_cnt  <= sat_inc(l1_hit_cnt);
      if (l1_lookup && !l1_hit) l1_miss_cnt <= sat_inc(l1_miss_cnt);
      if (l2_lookup && l2_hit)  l2_hit_cnt  <= sat_inc(l2_hit_cnt);
      if (l2_lookup && !l2_hit) l2_miss_cnt <= sat_inc(l2_miss_cnt);
    end
  end
`else
  assign l1_hit_cnt  = '0;
  assign l1_miss_cnt = '0;
  assign l2_hit_cnt  = '0;
  assign l2_miss_cnt = '0;
`endif

endmodule
